fetch_unit: RTL and testbench

Instruction fetch stage for the two-phase RV32 core. Owns the PC, runs a req/ack read on instruction memory, and latches the fetched word into an instruction register. It presents opcode/instruction/PC to the control and decode stage over a valid/ready handshake, and accepts PC redirects from branch resolution.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_pc.sv | 76 +++++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants for the two-phase RV32 core.
// Opcode constants are also consumed by the control stage.
package fetch_pkg;

  localparam int OPCODE_W = 7;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 2'd0;
  localparam fetch_state_t S_REQ   = 2'd1;
  localparam fetch_state_t S_HOLD  = 2'd2;
  localparam fetch_state_t S_FAULT = 2'd3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_pc.sv
// PC register, pending-redirect register, +4 incrementer and
// next-PC priority mux for the fetch stage.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  fetch_state_t       state,
  input  logic               imem_ack,
  input  logic               redir,
  input  logic [XLEN-1:0]    redir_pc,
  input  logic               consume,
  output logic [XLEN-1:0]    pc,
  output logic               pend
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] tgt_d;
  logic            pend_q;
  logic            pend_d;
  logic            in_req;
  logic            sel_redir;
  logic            sel_pend;
  logic            sel_inc;

  assign in_req = (state == S_REQ);

  // A redirect during an unacked read is parked until the read retires.
  assign sel_redir = redir &&
    ((state == S_IDLE) || (state == S_HOLD) ||
     (in_req && imem_ack));
  assign sel_pend = in_req && imem_ack && pend_q && !redir;
  assign sel_inc  = (state == S_HOLD) && consume && !redir;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      sel_redir: pc_d = redir_pc;
      sel_pend:  pc_d = tgt_q;
      sel_inc:   pc_d = pc_q + XLEN'(4);
      default:   pc_d = pc_q;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    if (in_req && imem_ack) begin
      pend_d = 1'b0;
    end else if (in_req && redir) begin
      pend_d = 1'b1;
      tgt_d  = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      tgt_q  <= RESET_PC;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tgt_q  <= tgt_d;
      pend_q <= pend_d;
    end
  end

  assign pc   = pc_q;
  assign pend = pend_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack imem read, instruction register.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [31:0]          if_instr,
  output logic [OPCODE_W-1:0]  if_opcode,
  output logic [XLEN-1:0]      if_pc,
  output logic                 fault
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  if_id_t          ir_q;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tgt;
  logic            pend;
  logic            misalign;
  logic            redir;
  logic            consume;
  logic            ir_load;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = redirect_valid &&
    (redirect_pc[1:0] != 2'b00) && (state_q != S_FAULT);
  assign tgt      = redirect_pc;
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  assign misalign  = 1'b0;
  assign tgt       = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  assign redir   = redirect_valid && !misalign &&
                   (state_q != S_FAULT);
  assign consume = if_valid && if_ready;
  assign ir_load = (state_q == S_REQ) && imem_ack &&
                   !redirect_valid && !pend;

  fetch_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_q),
    .imem_ack (imem_ack),
    .redir    (redir),
    .redir_pc (tgt),
    .consume  (consume),
    .pc       (pc),
    .pend     (pend)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (ir_load) state_d = S_HOLD;
      S_HOLD: if (redir || consume) state_d = S_REQ;
      default: state_d = state_q;
    endcase
    if (misalign) state_d = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q.instr <= NOP_INSTR;
      ir_q.pc    <= RESET_PC;
    end else if (misalign) begin
      ir_q.pc    <= redirect_pc;
    end else if (ir_load) begin
      ir_q.instr <= imem_rdata;
      ir_q.pc    <= pc;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc;
  assign if_valid  = (state_q == S_HOLD);
  assign fault     = (state_q == S_FAULT);
  assign if_instr  = ir_q.instr;
  assign if_opcode = ir_q.instr[OPCODE_W-1:0];
  assign if_pc     = ir_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a wait-state imem model.
// Memory word at address A is 32'hC0DE_0000 + A.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [31:0] if_pc;
  logic        fault;

  int total;
  int bad;
  int waits;
  int cnt;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = 32'hC0DE_0000 + imem_addr;
  assign imem_ack   = imem_req && (cnt == waits);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    waits = 0;
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    total++;
    if (imem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr);
    end
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", if_valid);
    end
    total++;
    if (if_instr !== 32'h13) begin
      bad++; $display("FAIL rst_instr got=%h exp=13", if_instr);
    end
    total++;
    if (if_opcode !== 7'h13) begin
      bad++; $display("FAIL rst_opc got=%h exp=13", if_opcode);
    end
    total++;
    if (if_pc !== 32'h0) begin
      bad++; $display("FAIL rst_pc got=%h exp=0", if_pc);
    end
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL rst_fault got=%b exp=0", fault);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1) begin
      bad++; $display("FAIL first_req got=%b exp=1", imem_req);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset();
    waits = 0;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0) begin
        bad++;
        $display("FAIL zw_req%0d got=%b/%h/%b exp=1/%h/0",
                 i, imem_req, imem_addr, if_valid, a);
      end
      @(negedge clk);
      total++;
      if (if_valid !== 1'b1 || imem_req !== 1'b0 ||
          if_instr !== 32'hC0DE_0000 + a || if_pc !== a) begin
        bad++;
        $display("FAIL zw_hold%0d got=%b/%b/%h/%h exp=1/0/%h/%h",
                 i, if_valid, imem_req, if_instr, if_pc,
                 32'hC0DE_0000 + a, a);
      end
      total++;
      if (if_opcode !== a[6:0]) begin
        bad++; $display("FAIL zw_opc%0d got=%h exp=%h", i, if_opcode, a[6:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wait_ready();
    do_reset();
    waits = 3;
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
        bad++;
        $display("FAIL wr_wait%0d got=%b/%h/%b exp=1/0/0",
                 i, imem_req, imem_addr, if_valid);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (if_valid !== 1'b1 || imem_req !== 1'b0 ||
          if_instr !== 32'hC0DE_0000 || imem_addr !== 32'h0) begin
        bad++;
        $display("FAIL wr_hold%0d got=%b/%b/%h/%h exp=1/0/c0de0000/0",
                 i, if_valid, imem_req, if_instr, imem_addr);
      end
      @(negedge clk);
    end
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL wr_next got=%b/%h exp=1/4", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    waits = 0;
    if_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL rh_addr got=%b/%h/%b exp=1/100/0",
               imem_req, imem_addr, if_valid);
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b1 || if_instr !== 32'hC0DE_0100 || if_pc !== 32'h100) begin
      bad++;
      $display("FAIL rh_instr got=%b/%h/%h exp=1/c0de0100/100",
               if_valid, if_instr, if_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    waits = 2;
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 ||
          if_valid !== 1'b0 || if_instr !== 32'h13) begin
        bad++;
        $display("FAIL rw_keep%0d got=%b/%h/%b/%h exp=1/0/0/13",
                 i, imem_req, imem_addr, if_valid, if_instr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200 ||
          if_valid !== 1'b0 || if_instr !== 32'h13) begin
        bad++;
        $display("FAIL rw_new%0d got=%b/%h/%b/%h exp=1/200/0/13",
                 i, imem_req, imem_addr, if_valid, if_instr);
      end
      @(negedge clk);
    end
    total++;
    if (if_valid !== 1'b1 || if_instr !== 32'hC0DE_0200 || if_pc !== 32'h200) begin
      bad++;
      $display("FAIL rw_hold got=%b/%h/%h exp=1/c0de0200/200",
               if_valid, if_instr, if_pc);
    end
    waits = 0;
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    total++;
    if (imem_addr !== 32'h204 || imem_ack !== 1'b1) begin
      bad++;
      $display("FAIL rw_seq got=%h/%b exp=204/1", imem_addr, imem_ack);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 ||
        if_valid !== 1'b0 || if_instr !== 32'hC0DE_0200) begin
      bad++;
      $display("FAIL rw_same got=%b/%h/%b/%h exp=1/200/0/c0de0200",
               imem_req, imem_addr, if_valid, if_instr);
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      bad++;
      $display("FAIL rw_same_hold got=%b/%h exp=1/200", if_valid, if_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    waits = 0;
    if_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_tgt got=%h exp=fffffffc", imem_addr);
    end
    if_ready = 1'b1;
    @(negedge clk);
    total++;
    if (if_valid !== 1'b1 || if_instr !== 32'hC0DD_FFFC) begin
      bad++;
      $display("FAIL wrap_instr got=%b/%h exp=1/c0ddfffc", if_valid, if_instr);
    end
    @(negedge clk);
    if_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    waits = 0;
    if_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      total++;
      if (fault !== 1'b1 || imem_req !== 1'b0 ||
          if_valid !== 1'b0 || if_pc !== 32'h102) begin
        bad++;
        $display("FAIL mis_fault%0d got=%b/%b/%b/%h exp=1/0/0/102",
                 i, fault, imem_req, if_valid, if_pc);
      end
      @(negedge clk);
    end
`else
    total++;
    if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL mis_align got=%b/%b/%h exp=0/1/100",
               fault, imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (if_pc !== 32'h100 || if_instr !== 32'hC0DE_0100) begin
      bad++;
      $display("FAIL mis_instr got=%h/%h exp=100/c0de0100", if_pc, if_instr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    waits = 0;
    if_ready = 1'b1;
    @(negedge clk);
    waits = 3;
    @(negedge clk);
    if_ready = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL rm_pre got=%b/%h exp=1/4", imem_req, imem_addr);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_instr !== 32'h13 || if_pc !== 32'h0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL rm_async got=%b/%h/%b/%h/%h/%b exp=0/0/0/13/0/0",
               imem_req, imem_addr, if_valid, if_instr, if_pc, fault);
    end
    @(negedge clk);
    waits = 0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rm_restart got=%b/%h exp=1/0", imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b1 || if_instr !== 32'hC0DE_0000) begin
      bad++;
      $display("FAIL rm_fetch got=%b/%h exp=1/c0de0000", if_valid, if_instr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_zero_wait();
    test_wait_ready();
    test_redirect_hold();
    test_redirect_wait();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
